instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Reader side of the 8-bit program ROM interface.
- Drives ROM output-enable and a 5-bit address from an internal program counter (PC).
- Captures the returned byte into an instruction register and presents it downstream with a valid/ready handshake.
- Handles jumps, PC wrap-around, out-of-range jump targets and downstream back-pressure. Sits between the program ROM and the instruction decoder.

Parameters:
- ADDR_W, 5, ROM address width.
- DATA_W, 8, ROM cell and instruction width.
- ROM_DEPTH, 16, number of populated ROM cells; valid addresses are 0..ROM_DEPTH-1.
- RESET_PC, 0, PC value after reset; must be < ROM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  fetch enable; 0 pauses fetching.
- rom_oe  out  1  ROM output enable.
- rom_addr  out  ADDR_W  ROM address.
- rom_data  in  DATA_W  ROM read data; combinational, valid in the same cycle as rom_oe/rom_addr.
- jmp_valid  in  1  jump request, single-cycle pulse.
- jmp_addr  in  ADDR_W  jump target.
- ir_valid  out  1  ir_data holds an unconsumed instruction.
- ir_ready  in  1  downstream accepts ir_data when ir_valid && ir_ready.
- ir_data  out  DATA_W  instruction register.
- ir_pc  out  ADDR_W  address ir_data was fetched from.
- fault  out  1  sticky; set on an out-of-range jump.

Behaviour:
- Reset (async assert, sync release): state=IDLE, PC=RESET_PC, rom_oe=0, rom_addr=0, ir_valid=0, ir_data=0, ir_pc=0, fault=0.
- rom_oe and rom_addr are registered outputs. rom_addr=PC whenever rom_oe=1; rom_addr=0 otherwise.
- FSM states: IDLE, FETCH, HOLD, FAULT.
- IDLE:
  - rom_oe=0.
  - en=1 -> FETCH next cycle, with rom_oe=1 and rom_addr=PC.
- FETCH (rom_oe=1), on each rising edge, in priority order:
  1. jmp_valid: handled per the jump rules below.
  2. en=0: -> IDLE. ir contents are unchanged.
  3. Slot free (ir_valid=0, or ir_valid && ir_ready): ir_data<=rom_data, ir_pc<=PC, ir_valid<=1, PC<=PC+1 with wrap.
  4. Slot occupied and not accepted: -> HOLD, rom_oe<=0.
- Throughput: one instruction per cycle while ir_ready=1. Latency from en rising to first ir_valid is 2 cycles.
- HOLD:
  - rom_oe=0; PC and ir are frozen.
  - ir_valid && ir_ready -> ir_valid<=0, then -> FETCH (or IDLE if en=0).
- PC wrap: the increment from ROM_DEPTH-1 yields 0. The PC never addresses cells ROM_DEPTH..2^ADDR_W-1 sequentially.
- Jump (any state except FAULT, takes priority over all else):
  - If jmp_addr < ROM_DEPTH: PC<=jmp_addr and ir_valid<=0 (flush, even if ir_ready=1 that cycle; the instruction is dropped, not delivered). Next state is FETCH if en=1, IDLE otherwise.
  - If jmp_addr >= ROM_DEPTH: fault<=1, ir_valid<=0, rom_oe<=0, -> FAULT.
- FAULT: all outputs held at reset values except fault=1. Exit only via rst_n.
- Simultaneous ir_ready accept and jmp_valid: the jump wins; the current ir is treated as flushed.
- en=0 while ir_valid=1: ir_valid stays 1 until consumed. No new fetch starts.
- rst_n asserted mid-fetch: all state returns to reset values immediately, regardless of clk.

Decomposition:
- Shared package `proc_pkg`:
  - ADDR_W, DATA_W and ROM_DEPTH constants.
  - The fetch state enumeration (IDLE, FETCH, HOLD, FAULT).
- Sub-module: `pc_counter`, holding the PC register with load (jump), increment-with-wrap at ROM_DEPTH, and hold.
- The FSM and instruction register stay in instr_fetch.

Test Plan:
- Reset, en=1, ir_ready=1, ROM cells 0..3 = 0x11,0x22,0x33,0x44 -> rom_oe rises 1 cycle after en; ir_data 0x11,0x22,0x33,0x44 on consecutive cycles with ir_pc 0,1,2,3; first ir_valid 2 cycles after en.
- Free-run from PC=14 with ir_ready=1 -> ir_pc sequence 14,15,0,1; rom_addr never exceeds 15.
- ir_ready=0 after the first instruction (0x11) -> ir_data holds 0x11, rom_oe=0 in HOLD, PC frozen at 1. Raise ir_ready -> 0x11 is consumed, then 0x22 follows with no loss or duplicate.
- jmp_valid with jmp_addr=9 while ir_valid=1 and ir_ready=1 -> ir_valid drops to 0 that cycle; the next delivered instruction has ir_pc=9 and ir_data=CELL09.
- jmp_addr=20 -> fault=1, rom_oe=0, ir_valid=0 from the next edge. Further en and jmp pulses are ignored. Asserting rst_n low clears fault and returns PC=RESET_PC.
- rst_n asserted asynchronously mid-FETCH, between clock edges -> rom_oe, ir_valid and fault go to 0 immediately. After release, fetching restarts from RESET_PC.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and the fetch state encoding for the program ROM reader.
package proc_pkg;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int ROM_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FAULT
    } fetch_state_e;
endpackage

// File: rtl/pc_counter.sv
// Program counter: load on jump, increment with wrap at ROM_DEPTH, otherwise hold.
// pc_nxt is exported so the fetch FSM can register rom_addr in step with the PC.
module pc_counter #(
    parameter int ADDR_W    = proc_pkg::ADDR_W,
    parameter int ROM_DEPTH = proc_pkg::ROM_DEPTH,
    parameter int RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_nxt
);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(ROM_DEPTH - 1);

    always_comb begin
        // NOTE: default assignment first so every path drives pc_nxt; no latch is inferred.
        pc_nxt = pc;
        if (load) begin
            pc_nxt = load_addr;
        end else if (inc) begin
            pc_nxt = (pc == LAST_PC) ? '0 : pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for registers so every flop samples pre-edge values.
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
        end else begin
            pc <= pc_nxt;
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// Program ROM reader: drives rom_oe/rom_addr from the PC and hands fetched bytes
// to the decoder through a valid/ready instruction register.
module instr_fetch #(
    parameter int ADDR_W    = proc_pkg::ADDR_W,
    parameter int DATA_W    = proc_pkg::DATA_W,
    parameter int ROM_DEPTH = proc_pkg::ROM_DEPTH,
    parameter int RESET_PC  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rom_oe,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              fault
);
    import proc_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(ROM_DEPTH);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nxt;
    logic              live;
    logic              accept;
    logic              slot_free;
    logic              jmp_ok;
    logic              pc_load;
    logic              pc_inc;

    assign live      = (state != FAULT);
    assign accept    = ir_valid && ir_ready;
    assign slot_free = !ir_valid || ir_ready;
    assign jmp_ok    = ({1'b0, jmp_addr} < DEPTH_X);
    assign pc_load   = live && jmp_valid && jmp_ok;
    assign pc_inc    = (state == FETCH) && !jmp_valid && en && slot_free;

    pc_counter #(
        .ADDR_W   (ADDR_W),
        .ROM_DEPTH(ROM_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .load_addr(jmp_addr),
        .inc      (pc_inc),
        .pc       (pc),
        .pc_nxt   (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_oe   <= 1'b0;
            rom_addr <= '0;
            ir_valid <= 1'b0;
            ir_data  <= '0;
            ir_pc    <= '0;
            fault    <= 1'b0;
        end else if (live && jmp_valid) begin
            // A jump flushes the instruction register even if it is being accepted.
            ir_valid <= 1'b0;
            if (jmp_ok) begin
                state    <= en ? FETCH : IDLE;
                rom_oe   <= en;
                rom_addr <= en ? pc_nxt : '0;
            end else begin
                state    <= FAULT;
                fault    <= 1'b1;
                rom_oe   <= 1'b0;
                rom_addr <= '0;
                ir_data  <= '0;
                ir_pc    <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) ir_valid <= 1'b0;
                    if (en) begin
                        state    <= FETCH;
                        rom_oe   <= 1'b1;
                        rom_addr <= pc;
                    end
                end
                FETCH: begin
                    if (!en) begin
                        state    <= IDLE;
                        rom_oe   <= 1'b0;
                        rom_addr <= '0;
                        if (accept) ir_valid <= 1'b0;
                    end else if (slot_free) begin
                        ir_data  <= rom_data;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        rom_addr <= pc_nxt;
                    end else begin
                        state    <= HOLD;
                        rom_oe   <= 1'b0;
                        rom_addr <= '0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        ir_valid <= 1'b0;
                        state    <= en ? FETCH : IDLE;
                        rom_oe   <= en;
                        rom_addr <= en ? pc : '0;
                    end
                end
                FAULT: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
